// File: rtl/axi_demultiplexer_buf.sv
// rtl/axi_demultiplexer_buf.sv - buffered 1-to-N valid/ready demultiplexer (optional: AXI_DEMUX_SEL_CHECK_EN)
module axi_demultiplexer_buf #(
  parameter int DATA_WIDTH = 64,
  parameter int N_OUT      = 16,
  parameter int SEL_WIDTH  = $clog2(N_OUT)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH-1:0]               IN_DATA,
  input  logic [SEL_WIDTH-1:0]                SEL,
  output logic [N_OUT-1:0]                    out_valid,
  input  logic [N_OUT-1:0]                    out_ready,
  output logic [N_OUT-1:0][DATA_WIDTH-1:0]    OUT_DATA,
  output logic                                sel_err
);

  // Two-entry ring buffer; count distinguishes full from empty when pointers match.
  logic [1:0]            count;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [DATA_WIDTH-1:0] data_mem [2];
  logic [SEL_WIDTH-1:0]  sel_mem  [2];

  logic [DATA_WIDTH-1:0] head_data;
  logic [SEL_WIDTH-1:0]  head_sel;
  logic                  head_vld;
  logic                  head_rdy;
  logic                  push;
  logic                  pop;
  logic                  store;

  // Ready depends only on the registered count, cutting the out_ready -> in_ready path.
  assign in_ready  = (count != 2'd2);
  assign push      = in_valid & in_ready;
  assign head_vld  = (count != 2'd0);
  assign head_data = data_mem[rd_ptr];
  assign head_sel  = sel_mem[rd_ptr];
  assign pop       = head_vld & head_rdy;

  // Steer the head entry onto its lane and pick up that lane's ready only.
  always_comb begin
    out_valid = '0;
    OUT_DATA  = '0;
    head_rdy  = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if (head_vld && (head_sel == SEL_WIDTH'(i))) begin
        out_valid[i] = 1'b1;
        OUT_DATA[i]  = head_data;
        head_rdy     = out_ready[i];
      end
    end
  end

`ifdef AXI_DEMUX_SEL_CHECK_EN
  logic sel_bad;
  logic sel_err_q;

  // Out-of-range selects are accepted on the handshake but never stored.
  assign sel_bad = ({1'b0, SEL} >= (SEL_WIDTH + 1)'(N_OUT));
  assign store   = push & ~sel_bad;
  assign sel_err = sel_err_q;

  // One-cycle error pulse following an absorbed out-of-range push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= push & sel_bad;
    end
  end
`else
  assign store   = push;
  assign sel_err = 1'b0;
`endif

  // Entry storage: written only at wr_ptr, so the displayed head never changes until popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        data_mem[i] <= '0;
        sel_mem[i]  <= '0;
      end
    end else if (store) begin
      data_mem[wr_ptr] <= IN_DATA;
      sel_mem[wr_ptr]  <= SEL;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (store) wr_ptr <= ~wr_ptr;
      if (pop)   rd_ptr <= ~rd_ptr;
      case ({store, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_demultiplexer_buf.sv
// tb/tb_axi_demultiplexer_buf.sv - scoreboard testbench for axi_demultiplexer_buf
module tb_axi_demultiplexer_buf;
  localparam int DW  = 64;
  localparam int N   = 16;
  localparam int SW  = 4;
  localparam int N12 = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [DW-1:0]         IN_DATA = '0;
  logic [SW-1:0]         SEL = '0;
  logic [N-1:0]          out_valid;
  logic [N-1:0]          out_ready = '0;
  logic [N-1:0][DW-1:0]  OUT_DATA;
  logic                  sel_err;

  logic                   in_valid12 = 1'b0;
  logic                   in_ready12;
  logic [DW-1:0]          in_data12 = '0;
  logic [SW-1:0]          sel12 = '0;
  logic [N12-1:0]         out_valid12;
  logic [N12-1:0]         out_ready12 = '0;
  logic [N12-1:0][DW-1:0] out_data12;
  logic                   sel_err12;

  int tests = 0;
  int fails = 0;

  logic [SW-1:0] q_sel[$];
  logic [DW-1:0] q_data[$];

  axi_demultiplexer_buf #(.DATA_WIDTH(DW), .N_OUT(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .IN_DATA(IN_DATA), .SEL(SEL),
    .out_valid(out_valid), .out_ready(out_ready), .OUT_DATA(OUT_DATA), .sel_err(sel_err)
  );

  axi_demultiplexer_buf #(.DATA_WIDTH(DW), .N_OUT(N12)) dut12 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid12), .in_ready(in_ready12), .IN_DATA(in_data12), .SEL(sel12),
    .out_valid(out_valid12), .out_ready(out_ready12), .OUT_DATA(out_data12), .sel_err(sel_err12)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== '0 || OUT_DATA !== '0 || sel_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold in_ready=%b out_valid=%h sel_err=%b required 1/0000/0", in_ready, out_valid, sel_err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; SEL = 4'd9; IN_DATA = 64'h0000_0000_0000_1234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid !== 16'h0200) begin
      fails++;
      $display("FAIL reset_prebeat out_valid=%h required 0200", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== '0 || in_ready !== 1'b1 || OUT_DATA !== '0) begin
      fails++;
      $display("FAIL reset_async out_valid=%h in_ready=%b required 0000/1", out_valid, in_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (out_valid !== '0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release out_valid=%h in_ready=%b required 0000/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_beat();
    logic [N-1:0][DW-1:0] exp_d;
    q_sel.delete(); q_data.delete();
    out_ready = '0;
    in_valid = 1'b1; SEL = 4'd5; IN_DATA = 64'h0000_0000_DEAD_BEEF;
    @(posedge clk);
    q_sel.push_back(SEL); q_data.push_back(IN_DATA);
    #1 in_valid = 1'b0;
    @(negedge clk);
    exp_d = '0;
    exp_d[q_sel[0]] = q_data[0];
    tests++;
    if (out_valid !== 16'h0020) begin
      fails++;
      $display("FAIL single_valid out_valid=%h required 0020", out_valid);
    end
    tests++;
    if (OUT_DATA !== exp_d) begin
      fails++;
      $display("FAIL single_data lane5=%h required %h", OUT_DATA[5], exp_d[5]);
    end
    out_ready[5] = 1'b1;
    @(posedge clk);
    void'(q_sel.pop_front()); void'(q_data.pop_front());
    #1;
    tests++;
    if (out_valid !== '0 || OUT_DATA !== '0) begin
      fails++;
      $display("FAIL single_pop out_valid=%h required 0000", out_valid);
    end
    out_ready = '0;
  endtask

  task automatic test_backpressure();
    out_ready = '0;
    in_valid = 1'b1; SEL = 4'd3; IN_DATA = 64'hAAAA_0000_0000_0003;
    @(posedge clk);
    q_sel.push_back(SEL); q_data.push_back(IN_DATA);
    #1 SEL = 4'd7; IN_DATA = 64'hBBBB_0000_0000_0007;
    @(posedge clk);
    q_sel.push_back(SEL); q_data.push_back(IN_DATA);
    #1 in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 16'h0008) begin
      fails++;
      $display("FAIL full_state in_ready=%b out_valid=%h required 0/0008", in_ready, out_valid);
    end
    out_ready = 16'h0080;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (out_valid !== 16'h0008 || in_ready !== 1'b0 || OUT_DATA[3] !== q_data[0]) begin
      fails++;
      $display("FAIL hol_block out_valid=%h in_ready=%b lane3=%h required 0008/0/%h", out_valid, in_ready, OUT_DATA[3], q_data[0]);
    end
    out_ready = 16'h0008;
    @(posedge clk);
    void'(q_sel.pop_front()); void'(q_data.pop_front());
    @(negedge clk);
    tests++;
    if (out_valid !== 16'h0080 || in_ready !== 1'b1 || OUT_DATA[q_sel[0]] !== q_data[0]) begin
      fails++;
      $display("FAIL after_pop out_valid=%h in_ready=%b lane7=%h required 0080/1/%h", out_valid, in_ready, OUT_DATA[7], q_data[0]);
    end
    out_ready = 16'h0080;
    @(posedge clk);
    void'(q_sel.pop_front()); void'(q_data.pop_front());
    @(negedge clk);
    tests++;
    if (out_valid !== '0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL drain out_valid=%h in_ready=%b required 0000/1", out_valid, in_ready);
    end
    out_ready = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_streaming();
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    int rdy_drop = 0;
    int s;
    logic push_ok, pop_ok;
    logic [N-1:0] exp_v;
    logic [N-1:0][DW-1:0] exp_d;
    q_sel.delete(); q_data.delete();
    out_ready = '1;
    while (recv < 100 && cyc < 300) begin
      in_valid = (sent < 100);
      SEL = SW'(sent % 16);
      IN_DATA = {32'(sent), $urandom()};
      @(negedge clk);
      exp_v = '0; exp_d = '0; s = 0;
      if (q_sel.size() != 0) begin
        s = int'(q_sel[0]);
        exp_v[s] = 1'b1;
        exp_d[s] = q_data[0];
      end
      tests++;
      if (out_valid !== exp_v) begin
        fails++;
        $display("FAIL stream_valid cyc=%0d out_valid=%h required %h", cyc, out_valid, exp_v);
      end
      tests++;
      if (OUT_DATA !== exp_d) begin
        fails++;
        $display("FAIL stream_data cyc=%0d lane%0d=%h required %h", cyc, s, OUT_DATA[s], exp_d[s]);
      end
      if (in_ready !== 1'b1) rdy_drop++;
      push_ok = in_valid && (q_sel.size() != 2);
      pop_ok  = (q_sel.size() != 0) && out_ready[q_sel[0]];
      @(posedge clk);
      if (pop_ok) begin
        void'(q_sel.pop_front()); void'(q_data.pop_front()); recv++;
      end
      if (push_ok) begin
        q_sel.push_back(SEL); q_data.push_back(IN_DATA); sent++;
      end
      #1 cyc++;
    end
    in_valid = 1'b0;
    tests++;
    if (recv != 100 || cyc != 101) begin
      fails++;
      $display("FAIL stream_rate recv=%0d cycles=%0d required 100/101", recv, cyc);
    end
    tests++;
    if (rdy_drop != 0) begin
      fails++;
      $display("FAIL stream_ready drops=%0d required 0", rdy_drop);
    end
    out_ready = '0;
  endtask

  task automatic test_back_to_back();
    int got [N];
    int s;
    logic push_ok, pop_ok;
    logic [N-1:0] exp_v;
    logic [N-1:0][DW-1:0] exp_d;
    q_sel.delete(); q_data.delete();
    foreach (got[i]) got[i] = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid = (cyc <= 10);
      SEL = SW'(cyc);
      IN_DATA = 64'hB2B0_0000_0000_0000 | 64'(cyc);
      out_ready = (cyc == 0) ? '0 : '1;
      @(negedge clk);
      exp_v = '0; exp_d = '0; s = 0;
      if (q_sel.size() != 0) begin
        s = int'(q_sel[0]);
        exp_v[s] = 1'b1;
        exp_d[s] = q_data[0];
      end
      tests++;
      if (out_valid !== exp_v || OUT_DATA !== exp_d) begin
        fails++;
        $display("FAIL b2b_head cyc=%0d out_valid=%h lane%0d=%h required %h/%h", cyc, out_valid, s, OUT_DATA[s], exp_v, exp_d[s]);
      end
      if (cyc >= 1 && cyc <= 10) begin
        tests++;
        if (!$onehot(out_valid) || in_ready !== 1'b1) begin
          fails++;
          $display("FAIL b2b_count1 cyc=%0d out_valid=%h in_ready=%b required onehot/1", cyc, out_valid, in_ready);
        end
      end
      push_ok = in_valid && (q_sel.size() != 2);
      pop_ok  = (q_sel.size() != 0) && out_ready[q_sel[0]];
      @(posedge clk);
      if (pop_ok) begin
        got[q_sel[0]]++;
        void'(q_sel.pop_front()); void'(q_data.pop_front());
      end
      if (push_ok) begin
        q_sel.push_back(SEL); q_data.push_back(IN_DATA);
      end
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid !== '0 || q_sel.size() != 0) begin
      fails++;
      $display("FAIL b2b_empty out_valid=%h pending=%0d required 0000/0", out_valid, q_sel.size());
    end
    for (int i = 0; i <= 10; i++) begin
      tests++;
      if (got[i] != 1) begin
        fails++;
        $display("FAIL b2b_once lane=%0d count=%0d required 1", i, got[i]);
      end
    end
    out_ready = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_sel_range();
    out_ready12 = '1;
`ifdef AXI_DEMUX_SEL_CHECK_EN
    in_valid12 = 1'b1; sel12 = 4'd13; in_data12 = 64'h0000_0000_0000_0D0D;
    @(posedge clk); #1;
    in_valid12 = 1'b0;
    @(negedge clk);
    tests++;
    if (sel_err12 !== 1'b1 || out_valid12 !== '0 || in_ready12 !== 1'b1) begin
      fails++;
      $display("FAIL selchk_pulse sel_err=%b out_valid=%h in_ready=%b required 1/000/1", sel_err12, out_valid12, in_ready12);
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (sel_err12 !== 1'b0 || out_valid12 !== '0) begin
      fails++;
      $display("FAIL selchk_once sel_err=%b out_valid=%h required 0/000", sel_err12, out_valid12);
    end
    in_valid12 = 1'b1; sel12 = 4'd2; in_data12 = 64'h0000_0000_0000_2222;
    @(posedge clk); #1;
    in_valid12 = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid12 !== 12'h004 || out_data12[2] !== 64'h0000_0000_0000_2222) begin
      fails++;
      $display("FAIL selchk_empty out_valid=%h lane2=%h required 004/2222", out_valid12, out_data12[2]);
    end
`else
    in_valid12 = 1'b1; sel12 = 4'd13; in_data12 = 64'h0000_0000_0000_0D0D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid12 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (out_valid12 !== '0 || in_ready12 !== 1'b0 || sel_err12 !== 1'b0) begin
      fails++;
      $display("FAIL selnochk_stall out_valid=%h in_ready=%b sel_err=%b required 000/0/0", out_valid12, in_ready12, sel_err12);
    end
`endif
    tests++;
    if (sel_err !== 1'b0) begin
      fails++;
      $display("FAIL sel_err16 sel_err=%b required 0", sel_err);
    end
    out_ready12 = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_backpressure();
    test_streaming();
    test_back_to_back();
    test_sel_range();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
